pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port cpu_clk, input, 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port cpu_rst, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port id_valid, input, 1: the ID stage holds a real instruction.
REQ-004 SHALL have ports id_rs1 and id_rs2, input, 5 each: ID source register indices.
REQ-005 SHALL have ports id_rs1_used and id_rs2_used, input, 1 each: the ID instruction reads rs1/rs2.
REQ-006 SHALL have ports id_wr, input, 5, and id_rf_we, input, 1: ID destination register and write enable.
REQ-007 SHALL have port id_is_load, input, 1: the ID instruction is a load (rf_wsel selects DRAM data).
REQ-008 SHALL have port ex_redirect, input, 1: the EX instruction changes flow (taken branch or jump; npc differs from pc+4).
REQ-009 SHALL have port pc_stall, output, 1: hold PC.
REQ-010 SHALL have port ifid_stall, output, 1: hold the IF/ID register.
REQ-011 SHALL have ports ifid_flush and idex_flush, output, 1 each: load a bubble into IF/ID or ID/EX.
REQ-012 SHALL have ports fwd_a_sel and fwd_b_sel, output, 2 each: 0 = regfile, 1 = EX ALU result, 2 = MEM result (ALU or DRAM rdata), 3 = WB wD.
REQ-013 SHALL have ports stall_cnt and flush_cnt, output, 16 each: saturating event counters.

Function
REQ-014 SHALL keep shadow stage records EX{wr,we,ld}, MEM{wr,we,ld} and WB{wr,we} that mirror the datapath pipeline registers.
REQ-015 SHALL update the shadow records every cycle: EX <= bubble if idex_flush is asserted, else the ID fields gated by id_valid; MEM <= EX; WB <= MEM.
REQ-016 SHALL treat a bubble as we=0, ld=0, wr=0.
REQ-017 SHALL compute hazard match(s, stage) = stage.we AND stage.wr == id_rs(s) AND id_rs(s) != 0 AND id_rs_used(s) AND id_valid.
REQ-018 SHALL define load_use = match on EX with EX.ld=1, for either source.
REQ-019 SHALL run an FSM with states RUN and STALL.
REQ-020 FSM in RUN: if load_use and not ex_redirect, assert pc_stall=1, ifid_stall=1, idex_flush=1 and go to STALL.
REQ-021 FSM in STALL: deassert the stall outputs and return to RUN, for exactly one bubble per load-use.
REQ-022 If the dependency persists in STALL, the next load_use evaluation SHALL use the updated shadows (the load is now in MEM), so no second stall occurs.
REQ-023 On ex_redirect=1, in any state, SHALL assert ifid_flush=1 and idex_flush=1, force pc_stall=ifid_stall=0, and go to RUN; flush overrides stall when both occur in the same cycle.
REQ-024 SHALL drive fwd_x_sel combinationally with priority EX(1) > MEM(2) > WB(3) > regfile(0), using the first matching stage.
REQ-025 An EX match with EX.ld=1 SHALL produce sel 0 (that instruction is stalled anyway).
REQ-026 SHALL never select forwarding for register x0 or when the corresponding id_rs_used=0.
REQ-027 stall_cnt SHALL increment on each cycle that pc_stall=1; flush_cnt SHALL increment on each cycle that ex_redirect=1; both SHALL saturate at 16'hFFFF.
REQ-028 pc_stall, ifid_stall, ifid_flush and idex_flush SHALL be combinational from state and inputs, with no extra latency.

Reset
REQ-029 While cpu_rst=0: FSM=RUN, all shadow records are bubbles, and stall_cnt=flush_cnt=0, applied immediately without waiting for a clock edge.
REQ-030 During reset: all stall/flush outputs=0 and fwd_a_sel=fwd_b_sel=0.
REQ-031 Reset asserted mid-STALL SHALL abort the stall; the first cycle after release SHALL be RUN with no bubble owed.

Verification
REQ-032 Back-to-back add x5 then add x6,x5,x5 -> fwd_a_sel=fwd_b_sel=1, no stall, stall_cnt=0.
REQ-033 lw x7 then add x8,x7,x0 -> one cycle with pc_stall=ifid_stall=idex_flush=1, then fwd_a_sel=2, stall_cnt=1.
REQ-034 ex_redirect=1 in the same cycle as a load-use -> ifid_flush=idex_flush=1, pc_stall=0, FSM=RUN, flush_cnt+1, stall_cnt unchanged.
REQ-035 Producer 3 instructions ahead writing x9, consumer reads x9 -> fwd sel=3; the same scenario with x0 as destination -> sel=0.
REQ-036 Assert cpu_rst=0 while in STALL -> outputs 0 immediately, counters 0; after release, a non-dependent instruction produces no stall.
REQ-037 Force 65536 redirects -> flush_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard control: load-use stall, redirect flush, forwarding select
module pipe_hazard_ctrl (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [4:0]  id_wr,
    input  logic        id_rf_we,
    input  logic        id_is_load,
    input  logic        ex_redirect,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t state, state_next;

    // Shadow copies of the destination fields held in the datapath pipeline registers
    logic [4:0] ex_wr, mem_wr, wb_wr;
    logic       ex_we, mem_we, wb_we;
    logic       ex_ld, mem_ld;

    logic a_act, b_act;
    logic a_ex, a_mem, a_wb;
    logic b_ex, b_mem, b_wb;
    logic load_use;

    // Per-source hazard matches against each downstream stage; x0 never matches
    always_comb begin
        a_act    = id_valid && id_rs1_used && (id_rs1 != 5'd0);
        b_act    = id_valid && id_rs2_used && (id_rs2 != 5'd0);
        a_ex     = a_act && ex_we  && (ex_wr  == id_rs1);
        a_mem    = a_act && mem_we && (mem_wr == id_rs1);
        a_wb     = a_act && wb_we  && (wb_wr  == id_rs1);
        b_ex     = b_act && ex_we  && (ex_wr  == id_rs2);
        b_mem    = b_act && mem_we && (mem_wr == id_rs2);
        b_wb     = b_act && wb_we  && (wb_wr  == id_rs2);
        load_use = ex_ld && (a_ex || b_ex);
    end

    // Forwarding select: nearest producer wins; a load still in EX cannot forward yet
    always_comb begin
        fwd_a_sel = 2'd0;
        fwd_b_sel = 2'd0;
        if (cpu_rst) begin
            if (a_ex)       fwd_a_sel = ex_ld ? 2'd0 : 2'd1;
            else if (a_mem) fwd_a_sel = 2'd2;
            else if (a_wb)  fwd_a_sel = 2'd3;
            if (b_ex)       fwd_b_sel = ex_ld ? 2'd0 : 2'd1;
            else if (b_mem) fwd_b_sel = 2'd2;
            else if (b_wb)  fwd_b_sel = 2'd3;
        end
    end

    // Next-state and stall/flush outputs; a redirect overrides any stall
    always_comb begin
        state_next = state;
        pc_stall   = 1'b0;
        ifid_stall = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (!cpu_rst) begin
            state_next = ST_RUN;
        end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_next = ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (load_use) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_flush = 1'b1;
                        state_next = ST_STALL;
                    end
                end
                ST_STALL: state_next = ST_RUN;
                default:  state_next = ST_RUN;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) state <= ST_RUN;
        else          state <= state_next;
    end

    // Shadow pipeline advance; an ID/EX flush inserts a bubble into EX
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            ex_wr  <= 5'd0; ex_we  <= 1'b0; ex_ld  <= 1'b0;
            mem_wr <= 5'd0; mem_we <= 1'b0; mem_ld <= 1'b0;
            wb_wr  <= 5'd0; wb_we  <= 1'b0;
        end else begin
            if (idex_flush || !id_valid) begin
                ex_wr <= 5'd0;
                ex_we <= 1'b0;
                ex_ld <= 1'b0;
            end else begin
                ex_wr <= id_wr;
                ex_we <= id_rf_we;
                ex_ld <= id_is_load;
            end
            mem_wr <= ex_wr;
            mem_we <= ex_we;
            mem_ld <= ex_ld;
            wb_wr  <= mem_wr;
            wb_we  <= mem_we;
        end
    end

    // Saturating stall and redirect event counters
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (pc_stall && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            if (ex_redirect && (flush_cnt != 16'hFFFF))
                flush_cnt <= flush_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic        cpu_clk;
    logic        cpu_rst;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2;
    logic        id_rs1_used, id_rs2_used;
    logic [4:0]  id_wr;
    logic        id_rf_we;
    logic        id_is_load;
    logic        ex_redirect;
    logic        pc_stall, ifid_stall, ifid_flush, idex_flush;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [15:0] stall_cnt, flush_cnt;

    int n_checks;
    int n_pass;

    pipe_hazard_ctrl dut (
        .cpu_clk     (cpu_clk),
        .cpu_rst     (cpu_rst),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_wr       (id_wr),
        .id_rf_we    (id_rf_we),
        .id_is_load  (id_is_load),
        .ex_redirect (ex_redirect),
        .pc_stall    (pc_stall),
        .ifid_stall  (ifid_stall),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] wr, input logic we, input logic ld);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs1_used = u1;
        id_rs2      = rs2;
        id_rs2_used = u2;
        id_wr       = wr;
        id_rf_we    = we;
        id_is_load  = ld;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #2;
    endtask

    task automatic do_reset();
        nop();
        ex_redirect = 1'b0;
        cpu_rst = 1'b0;
        tick();
        cpu_rst = 1'b1;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        nop();
        ex_redirect = 1'b1;
        cpu_rst     = 1'b0;
        #1;
        check("rst_ifid_flush", ifid_flush, 0);
        check("rst_idex_flush", idex_flush, 0);
        check("rst_pc_stall",   pc_stall,   0);
        check("rst_fwd_a",      fwd_a_sel,  0);
        check("rst_stall_cnt",  stall_cnt,  0);
        check("rst_flush_cnt",  flush_cnt,  0);
        ex_redirect = 1'b0;
        tick();
        cpu_rst = 1'b1;
        #1;

        // add x5,x1,x2 then add x6,x5,x5: EX forward on both sources
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
        #1 check("alu_prod_stall", pc_stall, 0);
        tick();
        set_id(1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0);
        #1;
        check("alu_fwd_a", fwd_a_sel, 1);
        check("alu_fwd_b", fwd_b_sel, 1);
        check("alu_no_stall", pc_stall, 0);
        tick();
        nop();
        #1 check("alu_stall_cnt", stall_cnt, 0);

        // lw x7,0(x1) then add x8,x7,x0: one bubble, then MEM forward
        do_reset();
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1);
        tick();
        set_id(1, 5'd7, 1, 5'd0, 1, 5'd8, 1, 0);
        #1;
        check("lu_pc_stall",   pc_stall,   1);
        check("lu_ifid_stall", ifid_stall, 1);
        check("lu_idex_flush", idex_flush, 1);
        check("lu_fwd_a_ld",   fwd_a_sel,  0);
        check("lu_fwd_b_x0",   fwd_b_sel,  0);
        tick();
        #1;
        check("lu2_pc_stall",   pc_stall,   0);
        check("lu2_idex_flush", idex_flush, 0);
        check("lu2_fwd_a",      fwd_a_sel,  2);
        check("lu2_stall_cnt",  stall_cnt,  1);
        tick();
        nop();
        #1;
        check("lu3_pc_stall",  pc_stall,  0);
        check("lu3_stall_cnt", stall_cnt, 1);

        // redirect in the same cycle as a load-use: flush wins
        do_reset();
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1);
        tick();
        set_id(1, 5'd7, 1, 5'd0, 1, 5'd8, 1, 0);
        ex_redirect = 1'b1;
        #1;
        check("rd_ifid_flush", ifid_flush, 1);
        check("rd_idex_flush", idex_flush, 1);
        check("rd_pc_stall",   pc_stall,   0);
        check("rd_ifid_stall", ifid_stall, 0);
        tick();
        ex_redirect = 1'b0;
        nop();
        #1;
        check("rd_flush_cnt", flush_cnt, 1);
        check("rd_stall_cnt", stall_cnt, 0);
        check("rd_run",       pc_stall,  0);

        // producer x9 seen from EX, MEM and WB in turn
        do_reset();
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd9, 1, 0);
        tick();
        set_id(1, 5'd9, 1, 5'd9, 1, 5'd0, 0, 0);
        #1 check("dist1_fwd_a", fwd_a_sel, 1);
        tick();
        #1 check("dist2_fwd_a", fwd_a_sel, 2);
        tick();
        #1;
        check("dist3_fwd_a", fwd_a_sel, 3);
        check("dist3_fwd_b", fwd_b_sel, 3);
        id_rs2_used = 1'b0;
        #1 check("dist3_unused_b", fwd_b_sel, 0);

        // two producers of x9: the nearer one (EX) wins over MEM
        do_reset();
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd9, 1, 0);
        tick();
        set_id(1, 5'd3, 1, 5'd4, 1, 5'd9, 1, 0);
        tick();
        set_id(1, 5'd9, 1, 5'd0, 0, 5'd0, 0, 0);
        #1 check("prio_ex_over_mem", fwd_a_sel, 1);

        // producer writing x0 three ahead: never forwarded
        do_reset();
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 0);
        tick();
        nop();
        tick();
        tick();
        set_id(1, 5'd0, 1, 5'd0, 1, 5'd10, 1, 0);
        #1;
        check("x0_fwd_a", fwd_a_sel, 0);
        check("x0_fwd_b", fwd_b_sel, 0);

        // reset asserted while in STALL
        do_reset();
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1);
        tick();
        set_id(1, 5'd7, 1, 5'd0, 0, 5'd8, 1, 0);
        tick();
        #1 check("rs_pre_cnt", stall_cnt, 1);
        cpu_rst = 1'b0;
        #1;
        check("rs_pc_stall",  pc_stall,  0);
        check("rs_fwd_a",     fwd_a_sel, 0);
        check("rs_stall_cnt", stall_cnt, 0);
        ex_redirect = 1'b1;
        #1 check("rs_ifid_flush", ifid_flush, 0);
        ex_redirect = 1'b0;
        tick();
        cpu_rst = 1'b1;
        set_id(1, 5'd7, 1, 5'd0, 0, 5'd8, 1, 0);
        #1;
        check("rs_post_stall", pc_stall,   0);
        check("rs_post_flush", idex_flush, 0);
        tick();
        nop();
        #1 check("rs_post_cnt", stall_cnt, 0);

        // flush counter saturation
        do_reset();
        ex_redirect = 1'b1;
        repeat (300) tick();
        check("sat_mid", flush_cnt, 300);
        repeat (65236) tick();
        check("sat_full", flush_cnt, 16'hFFFF);
        tick();
        check("sat_hold", flush_cnt, 16'hFFFF);
        ex_redirect = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
